// File: rtl/rf_mem_pkg.sv
// -----------------------------------------------------------------------------
// rf_mem_pkg
// Shared types and constants for the burst read master and its stream FIFO.
//   burst_state_t  : burst master FSM state encoding
//   WORD_BYTES     : bytes per memory word (address step per word)
//   DEF_MAX_BURST  : default maximum words per burst
//   DEF_FIFO_DEPTH : default stream FIFO depth in words
//   min_burst()    : size of the next burst given the words still to read
// -----------------------------------------------------------------------------
package rf_mem_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_SPACE     = 3'd1,
        ST_ISSUE     = 3'd2,
        ST_WAIT_DATA = 3'd3,
        ST_FINISH    = 3'd4
    } burst_state_t;

    localparam logic [31:0] WORD_BYTES     = 32'd4;
    localparam int          DEF_MAX_BURST  = 16;
    localparam int          DEF_FIFO_DEPTH = 32;

    // Smaller of the outstanding word count and the burst limit.
    function automatic logic [7:0] min_burst(input logic [23:0] remaining,
                                             input logic [7:0]  max_burst);
        if (remaining < {16'd0, max_burst}) begin
            min_burst = remaining[7:0];
        end else begin
            min_burst = max_burst;
        end
    endfunction

endpackage

// File: rtl/rf_sync_fifo.sv
// -----------------------------------------------------------------------------
// rf_sync_fifo
// Synchronous FIFO with a registered show-ahead head: a word pushed at an edge
// is presented on oValid/oData in the following cycle.
//   clk, reset_n : clock, synchronous active-low reset (contents discarded)
//   iPush, iData : write request and word
//   iPop         : consumer ready; a pop happens when iPop and oValid are high
//   oValid,oData : registered head of the FIFO
//   oFree        : number of free slots (0..DEPTH)
//   oOverflow    : sticky, a push arrived while full without a pop
// -----------------------------------------------------------------------------
module rf_sync_fifo #(
    parameter int  DEPTH = 32,
    parameter int  WIDTH = 33,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             iPush,
    input  logic [WIDTH-1:0] iData,
    input  logic             iPop,
    output logic             oValid,
    output logic [WIDTH-1:0] oData,
    output logic [AW:0]      oFree,
    output logic             oOverflow
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d, occ_s;
    logic             valid_q, valid_d, overflow_q, overflow_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             pop_s, full_s, push_ok_s;

    // Pointer/occupancy update and next value of the registered head.
    always_comb begin
        pop_s      = iPop & valid_q;
        full_s     = (count_q == (AW+1)'(DEPTH));
        // A full FIFO still accepts a word when one leaves in the same cycle.
        push_ok_s  = iPush & (~full_s | pop_s);
        count_d    = count_q + (AW+1)'(push_ok_s) - (AW+1)'(pop_s);
        wr_ptr_d   = wr_ptr_q + AW'(push_ok_s);
        rd_ptr_d   = rd_ptr_q + AW'(pop_s);
        overflow_d = overflow_q | (iPush & full_s & ~pop_s);
        occ_s      = count_q - (AW+1)'(pop_s);
        // Nothing left after the pop: the incoming word (if any) bypasses
        // storage straight into the head register.
        if (occ_s == {(AW+1){1'b0}}) begin
            valid_d = push_ok_s;
            if (push_ok_s) begin
                data_d = iData;
            end else begin
                data_d = data_q;
            end
        end else begin
            valid_d = 1'b1;
            data_d  = mem_q[rd_ptr_d];
        end
    end

    // Storage array write port; contents need no reset.
    always_ff @(posedge clk) begin
        if (push_ok_s) begin
            mem_q[wr_ptr_q] <= iData;
        end
    end

    // Control and head registers.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_ptr_q   <= {AW{1'b0}};
            rd_ptr_q   <= {AW{1'b0}};
            count_q    <= {(AW+1){1'b0}};
            valid_q    <= 1'b0;
            data_q     <= {WIDTH{1'b0}};
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            valid_q    <= valid_d;
            data_q     <= data_d;
            overflow_q <= overflow_d;
        end
    end

    assign oValid    = valid_q;
    assign oData     = data_q;
    assign oFree     = (AW+1)'(DEPTH) - count_q;
    assign oOverflow = overflow_q;

endmodule

// File: rtl/burst_read_master.sv
// -----------------------------------------------------------------------------
// burst_read_master
// Splits a linear read command into bursts of at most MAX_BURST words, issues
// them one at a time on a burst-read memory port and streams the returned
// words out through a FIFO, flagging the final word of the command.
//   clk, reset_n                         : clock, synchronous active-low reset
//   iCmdValid/oCmdReady/iCmdAddr/iCmdWords : command (byte address, word count)
//   oRead/oAddress/oBurstcount/iWaitrequest : burst request to memory
//   iDatavalid/iData                     : returned read words
//   oStreamValid/oStreamData/oStreamLast/iStreamReady : output stream
//   oBusy, oDone, oOverflow              : status (oDone pulses at completion)
// -----------------------------------------------------------------------------
module burst_read_master
    import rf_mem_pkg::*;
#(
    parameter int MAX_BURST  = DEF_MAX_BURST,
    parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        iCmdValid,
    output logic        oCmdReady,
    input  logic [31:0] iCmdAddr,
    input  logic [23:0] iCmdWords,
    output logic        oRead,
    output logic [31:0] oAddress,
    output logic [7:0]  oBurstcount,
    input  logic        iWaitrequest,
    input  logic        iDatavalid,
    input  logic [31:0] iData,
    output logic        oStreamValid,
    output logic [31:0] oStreamData,
    output logic        oStreamLast,
    input  logic        iStreamReady,
    output logic        oBusy,
    output logic        oDone,
    output logic        oOverflow
);

    localparam int FREE_W = $clog2(FIFO_DEPTH) + 1;

    burst_state_t  state_q, state_d;
    logic [31:0]   addr_q, addr_d, address_q, address_d;
    logic [23:0]   remaining_q, remaining_d;
    logic [7:0]    burst_q, burst_d, rx_cnt_q, rx_cnt_d, burstcount_q, burstcount_d;
    logic          read_q, read_d, done_q, done_d;
    logic          cmd_ready_q, cmd_ready_d, busy_q, busy_d;

    logic [7:0]        burst_s;
    logic              space_ok_s, last_word_s, final_beat_s, stream_pop_s;
    logic              fifo_push_s, fifo_valid_s, fifo_ovf_s;
    logic [32:0]       fifo_wdata_s, fifo_rdata_s;
    logic [FREE_W-1:0] fifo_free_s;
    logic              unused_addr_lsb_s;

    // Byte-lane bits of the command address are forced to zero.
    assign unused_addr_lsb_s = ^iCmdAddr[1:0];

    // Burst sequencing: next-state and next-output computation.
    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        remaining_d  = remaining_q;
        burst_d      = burst_q;
        rx_cnt_d     = rx_cnt_q;
        read_d       = read_q;
        address_d    = address_q;
        burstcount_d = burstcount_q;
        done_d       = 1'b0;
        fifo_push_s  = 1'b0;

        burst_s      = min_burst(remaining_q, 8'(MAX_BURST));
        // Only issue a burst the FIFO can fully absorb, so returned data is never dropped.
        space_ok_s   = ({{(32-FREE_W){1'b0}}, fifo_free_s} >= {24'd0, burst_s});
        stream_pop_s = fifo_valid_s & iStreamReady;
        final_beat_s = iDatavalid & (rx_cnt_q == (burst_q - 8'd1));
        last_word_s  = (remaining_q == {16'd0, burst_q}) & (rx_cnt_q == (burst_q - 8'd1));

        case (state_q)
            ST_IDLE: begin
                if (iCmdValid) begin
                    if (iCmdWords != 24'd0) begin
                        addr_d      = {iCmdAddr[31:2], 2'b00};
                        remaining_d = iCmdWords;
                        state_d     = ST_SPACE;
                    end else begin
                        done_d = 1'b1;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SPACE: begin
                if (space_ok_s) begin
                    burst_d      = burst_s;
                    address_d    = addr_q;
                    burstcount_d = burst_s;
                    read_d       = 1'b1;
                    state_d      = ST_ISSUE;
                end else begin
                    state_d = ST_SPACE;
                end
            end
            ST_ISSUE: begin
                if (!iWaitrequest) begin
                    read_d   = 1'b0;
                    rx_cnt_d = 8'd0;
                    state_d  = ST_WAIT_DATA;
                end else begin
                    state_d = ST_ISSUE;
                end
            end
            ST_WAIT_DATA: begin
                fifo_push_s = iDatavalid;
                if (final_beat_s) begin
                    rx_cnt_d    = rx_cnt_q + 8'd1;
                    remaining_d = remaining_q - {16'd0, burst_q};
                    addr_d      = addr_q + ({24'd0, burst_q} * WORD_BYTES);
                    if (remaining_q == {16'd0, burst_q}) begin
                        state_d = ST_FINISH;
                    end else begin
                        state_d = ST_SPACE;
                    end
                end else if (iDatavalid) begin
                    rx_cnt_d = rx_cnt_q + 8'd1;
                end else begin
                    rx_cnt_d = rx_cnt_q;
                end
            end
            ST_FINISH: begin
                if (stream_pop_s && fifo_rdata_s[32]) begin
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_FINISH;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        cmd_ready_d = (state_d == ST_IDLE);
        busy_d      = (state_d != ST_IDLE);
    end

    assign fifo_wdata_s = {last_word_s, iData};

    // FSM state and registered outputs.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            addr_q       <= 32'd0;
            remaining_q  <= 24'd0;
            burst_q      <= 8'd0;
            rx_cnt_q     <= 8'd0;
            read_q       <= 1'b0;
            address_q    <= 32'd0;
            burstcount_q <= 8'd0;
            done_q       <= 1'b0;
            cmd_ready_q  <= 1'b1;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            remaining_q  <= remaining_d;
            burst_q      <= burst_d;
            rx_cnt_q     <= rx_cnt_d;
            read_q       <= read_d;
            address_q    <= address_d;
            burstcount_q <= burstcount_d;
            done_q       <= done_d;
            cmd_ready_q  <= cmd_ready_d;
            busy_q       <= busy_d;
        end
    end

    rf_sync_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (33)
    ) u_fifo (
        .clk       (clk),
        .reset_n   (reset_n),
        .iPush     (fifo_push_s),
        .iData     (fifo_wdata_s),
        .iPop      (iStreamReady),
        .oValid    (fifo_valid_s),
        .oData     (fifo_rdata_s),
        .oFree     (fifo_free_s),
        .oOverflow (fifo_ovf_s)
    );

    assign oCmdReady    = cmd_ready_q;
    assign oBusy        = busy_q;
    assign oDone        = done_q;
    assign oRead        = read_q;
    assign oAddress     = address_q;
    assign oBurstcount  = burstcount_q;
    assign oStreamValid = fifo_valid_s;
    assign oStreamData  = fifo_rdata_s[31:0];
    assign oStreamLast  = fifo_rdata_s[32];
    assign oOverflow    = fifo_ovf_s;

endmodule

// File: tb/tb_burst_read_master.sv
// -----------------------------------------------------------------------------
// tb_burst_read_master
// Directed bench for burst_read_master (MAX_BURST 16, FIFO_DEPTH 32) with a
// behavioural burst memory whose word at index w is pat(w).
// -----------------------------------------------------------------------------
module tb_burst_read_master;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        iCmdValid;
    logic        oCmdReady;
    logic [31:0] iCmdAddr;
    logic [23:0] iCmdWords;
    logic        oRead;
    logic [31:0] oAddress;
    logic [7:0]  oBurstcount;
    logic        iWaitrequest;
    logic        iDatavalid;
    logic [31:0] iData;
    logic        oStreamValid;
    logic [31:0] oStreamData;
    logic        oStreamLast;
    logic        iStreamReady;
    logic        oBusy;
    logic        oDone;
    logic        oOverflow;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    logic [31:0] acc_addr[$];
    logic [7:0]  acc_cnt[$];
    logic [31:0] rx_data[$];
    logic        rx_last[$];
    int          done_cnt, done_cyc, lastpop_cyc, read_cyc_cnt, busy_cnt, delivered;
    int          stall_req = 0;
    logic [31:0] mem_a;
    logic [7:0]  mem_c;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    burst_read_master dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .iCmdValid    (iCmdValid),
        .oCmdReady    (oCmdReady),
        .iCmdAddr     (iCmdAddr),
        .iCmdWords    (iCmdWords),
        .oRead        (oRead),
        .oAddress     (oAddress),
        .oBurstcount  (oBurstcount),
        .iWaitrequest (iWaitrequest),
        .iDatavalid   (iDatavalid),
        .iData        (iData),
        .oStreamValid (oStreamValid),
        .oStreamData  (oStreamData),
        .oStreamLast  (oStreamLast),
        .iStreamReady (iStreamReady),
        .oBusy        (oBusy),
        .oDone        (oDone),
        .oOverflow    (oOverflow)
    );

    // Memory contents: word index -> data.
    function automatic logic [31:0] pat(input logic [31:0] widx);
        return 32'hA500_0000 + (widx * 32'h0001_0001);
    endfunction

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic clear_logs();
        acc_addr.delete();
        acc_cnt.delete();
        rx_data.delete();
        rx_last.delete();
        done_cnt     = 0;
        done_cyc     = 0;
        lastpop_cyc  = 0;
        read_cyc_cnt = 0;
        busy_cnt     = 0;
        delivered    = 0;
    endtask

    task automatic start_cmd(input logic [31:0] addr, input logic [23:0] words);
        iCmdValid = 1'b1;
        iCmdAddr  = addr;
        iCmdWords = words;
        @(posedge clk);
        #1;
        iCmdValid = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int n = 0;
        while (done_cnt == 0 && n < budget) begin
            @(posedge clk);
            #1;
            n++;
        end
        check_value("done_seen", 32'(done_cnt > 0), 32'd1);
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic verify_stream(input logic [31:0] base, input int n);
        check_value("rx_count", 32'(rx_data.size()), 32'(n));
        for (int i = 0; i < n && i < rx_data.size(); i++) begin
            check_value($sformatf("rx_data[%0d]", i), rx_data[i], pat((base >> 2) + 32'(i)));
            check_value($sformatf("rx_last[%0d]", i), 32'(rx_last[i]), 32'(i == n - 1));
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check_value({tag, "_read"},   32'(oRead),        32'd0);
        check_value({tag, "_addr"},   oAddress,          32'd0);
        check_value({tag, "_bcnt"},   32'(oBurstcount),  32'd0);
        check_value({tag, "_ready"},  32'(oCmdReady),    32'd1);
        check_value({tag, "_busy"},   32'(oBusy),        32'd0);
        check_value({tag, "_done"},   32'(oDone),        32'd0);
        check_value({tag, "_ovf"},    32'(oOverflow),    32'd0);
        check_value({tag, "_svalid"}, 32'(oStreamValid), 32'd0);
        check_value({tag, "_sdata"},  oStreamData,       32'd0);
        check_value({tag, "_slast"},  32'(oStreamLast),  32'd0);
    endtask

    // Burst memory: accepts one request, optionally stalls it, then returns its words.
    initial begin
        iWaitrequest = 1'b0;
        iDatavalid   = 1'b0;
        iData        = 32'd0;
        forever begin
            @(negedge clk);
            if (reset_n === 1'b1 && oRead === 1'b1) begin
                mem_a = oAddress;
                mem_c = oBurstcount;
                if (stall_req > 0) begin
                    iWaitrequest = 1'b1;
                    for (int k = 0; k < stall_req; k++) begin
                        @(negedge clk);
                        check_value("stall_read", 32'(oRead), 32'd1);
                        check_value("stall_addr", oAddress, mem_a);
                        check_value("stall_bcnt", 32'(oBurstcount), 32'(mem_c));
                    end
                    stall_req    = 0;
                    iWaitrequest = 1'b0;
                end
                acc_addr.push_back(mem_a);
                acc_cnt.push_back(mem_c);
                @(negedge clk);
                for (int k = 0; k < int'(mem_c); k++) begin
                    if (reset_n !== 1'b1) break;
                    iDatavalid = 1'b1;
                    iData      = pat((mem_a >> 2) + 32'(k));
                    delivered++;
                    @(negedge clk);
                end
                iDatavalid = 1'b0;
            end
        end
    end

    // Output monitor: records stream pops, done pulses, read and busy cycles.
    initial begin
        forever begin
            @(negedge clk);
            if (reset_n === 1'b1) begin
                if (oStreamValid && iStreamReady) begin
                    rx_data.push_back(oStreamData);
                    rx_last.push_back(oStreamLast);
                    if (oStreamLast) lastpop_cyc = cyc;
                end
                if (oDone) begin
                    done_cnt++;
                    done_cyc = cyc;
                end
                if (oRead) read_cyc_cnt++;
                if (oBusy) busy_cnt++;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n      = 1'b0;
        iCmdValid    = 1'b0;
        iCmdAddr     = 32'd0;
        iCmdWords    = 24'd0;
        iStreamReady = 1'b1;
        clear_logs();
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("rst");
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        // Single burst with command-to-read latency.
        clear_logs();
        start_cmd(32'h0000_0100, 24'd4);
        @(negedge clk);
        check_value("s1_busy_e1",  32'(oBusy),     32'd1);
        check_value("s1_ready_e1", 32'(oCmdReady), 32'd0);
        check_value("s1_read_e1",  32'(oRead),     32'd0);
        @(negedge clk);
        check_value("s1_read_e2",  32'(oRead),       32'd1);
        check_value("s1_addr_e2",  oAddress,         32'h0000_0100);
        check_value("s1_bcnt_e2",  32'(oBurstcount), 32'd4);
        wait_done(200);
        check_value("s1_nbursts", 32'(acc_addr.size()), 32'd1);
        verify_stream(32'h0000_0100, 4);
        check_value("s1_ndone", 32'(done_cnt), 32'd1);
        check_value("s1_done_lat", 32'(done_cyc - lastpop_cyc), 32'd1);

        // Split command; unaligned start address is rounded down.
        clear_logs();
        start_cmd(32'h0000_0003, 24'd40);
        wait_done(400);
        check_value("sp_nbursts", 32'(acc_addr.size()), 32'd3);
        for (int i = 0; i < 3 && i < acc_addr.size(); i++) begin
            check_value($sformatf("sp_addr[%0d]", i), acc_addr[i], 32'(i) * 32'h40);
            check_value($sformatf("sp_bcnt[%0d]", i), 32'(acc_cnt[i]), (i == 2) ? 32'd8 : 32'd16);
        end
        verify_stream(32'h0000_0000, 40);

        // Backpressure: FIFO fills after two bursts.
        clear_logs();
        iStreamReady = 1'b0;
        start_cmd(32'h0000_1000, 24'd48);
        repeat (150) @(posedge clk);
        #1;
        check_value("bp_nbursts_held", 32'(acc_addr.size()), 32'd2);
        check_value("bp_read_low", 32'(oRead), 32'd0);
        check_value("bp_busy", 32'(oBusy), 32'd1);
        check_value("bp_no_pop", 32'(rx_data.size()), 32'd0);
        iStreamReady = 1'b1;
        wait_done(600);
        check_value("bp_nbursts", 32'(acc_addr.size()), 32'd3);
        if (acc_addr.size() > 2) begin
            check_value("bp_addr3", acc_addr[2], 32'h0000_1080);
            check_value("bp_bcnt3", 32'(acc_cnt[2]), 32'd16);
        end
        verify_stream(32'h0000_1000, 48);
        check_value("bp_ovf", 32'(oOverflow), 32'd0);

        // Waitrequest stall during ISSUE.
        clear_logs();
        stall_req = 5;
        start_cmd(32'h0000_0200, 24'd8);
        wait_done(300);
        check_value("st_nbursts", 32'(acc_addr.size()), 32'd1);
        check_value("st_read_cycles", 32'(read_cyc_cnt), 32'd6);
        verify_stream(32'h0000_0200, 8);

        // Zero-length command.
        clear_logs();
        start_cmd(32'h0000_0500, 24'd0);
        @(negedge clk);
        check_value("z_done_hi", 32'(oDone), 32'd1);
        check_value("z_busy", 32'(oBusy), 32'd0);
        check_value("z_ready", 32'(oCmdReady), 32'd1);
        @(negedge clk);
        check_value("z_done_lo", 32'(oDone), 32'd0);
        repeat (10) @(posedge clk);
        #1;
        check_value("z_nreads", 32'(read_cyc_cnt), 32'd0);
        check_value("z_ndone", 32'(done_cnt), 32'd1);
        check_value("z_busy_cycles", 32'(busy_cnt), 32'd0);

        // Reset after 3 of 16 words, then a fresh command.
        clear_logs();
        start_cmd(32'h0000_0800, 24'd16);
        begin
            int n = 0;
            while (delivered < 3 && n < 100) begin
                @(posedge clk);
                #1;
                n++;
            end
        end
        check_value("rm_three_words", 32'(delivered), 32'd3);
        reset_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check_reset_outputs("rm");
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        clear_logs();
        start_cmd(32'h0000_0040, 24'd5);
        wait_done(200);
        check_value("rm_nbursts", 32'(acc_addr.size()), 32'd1);
        if (acc_addr.size() > 0) begin
            check_value("rm_addr", acc_addr[0], 32'h0000_0040);
        end
        verify_stream(32'h0000_0040, 5);
        check_value("rm_ovf", 32'(oOverflow), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
